lin_map_pipe: RTL and testbench

LIN_MAP_PIPE -- requirements
Module: lin_map_pipe

---
 rtl/lin_map_pkg.sv | 30 +++
 rtl/lin_map_stage.sv | 38 +++
 rtl/lin_map_pipe.sv | 95 +++++++++
 tb/tb_lin_map_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lin_map_pkg.sv
// Shared definitions for the linear-map pipeline: mode encoding and the two
// tower-field basis-change maps used around the S-box core.
package lin_map_pkg;

    localparam int         MODE_W       = 2;
    localparam logic [1:0] MODE_OUT_MAP = 2'd0;
    localparam logic [1:0] MODE_IN_MAP  = 2'd1;

    // Each constant is the image of one input bit; the map is the XOR of the selected images.
    function automatic logic [7:0] in_map(input logic [7:0] x);
        in_map = ({8{x[0]}} & 8'hFF) ^ ({8{x[1]}} & 8'hA9) ^ ({8{x[2]}} & 8'h81)
               ^ ({8{x[3]}} & 8'h09) ^ ({8{x[4]}} & 8'h48) ^ ({8{x[5]}} & 8'hF2)
               ^ ({8{x[6]}} & 8'hF3) ^ ({8{x[7]}} & 8'h98);
    endfunction

    function automatic logic [7:0] out_map(input logic [7:0] x);
        out_map = ({8{x[0]}} & 8'h24) ^ ({8{x[1]}} & 8'h03) ^ ({8{x[2]}} & 8'h04)
                ^ ({8{x[3]}} & 8'hDC) ^ ({8{x[4]}} & 8'h0B) ^ ({8{x[5]}} & 8'h9E)
                ^ ({8{x[6]}} & 8'h2D) ^ ({8{x[7]}} & 8'h58);
    endfunction

    function automatic logic [7:0] map_byte(input logic [MODE_W-1:0] mode, input logic [7:0] x);
        case (mode)
            MODE_OUT_MAP: map_byte = out_map(x);
            MODE_IN_MAP:  map_byte = in_map(x);
            default:      map_byte = x;
        endcase
    endfunction

endpackage

// File: rtl/lin_map_stage.sv
// One pipeline slot: valid bit plus mode/data register, loading when empty
// or when the downstream side takes the current beat in the same cycle.
module lin_map_stage
    import lin_map_pkg::*;
#(
    parameter int W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [W-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MODE_W-1:0] out_mode,
    output logic [W-1:0]      out_data
);

    logic load;

    assign load = !out_valid || out_ready;

    // Payload only changes when a beat actually arrives, so an idle slot keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mode  <= '0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_mode <= in_mode;
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/lin_map_pipe.sv
// Share-wise basis-change map followed by a skid-free valid/ready pipeline.
// Optional share refresh after the map is enabled with LIN_MAP_REFRESH_EN.
module lin_map_pipe
    import lin_map_pkg::*;
#(
    parameter int NUM_SHARES  = 2,
    parameter int PIPE_STAGES = 1
) (
    input  logic                    ClkxCI,
    input  logic                    RstxBI,
    input  logic                    InValidxSI,
    output logic                    InReadyxSO,
    input  logic [MODE_W-1:0]       ModexSI,
    input  logic [8*NUM_SHARES-1:0] DataInxDI,
`ifdef LIN_MAP_REFRESH_EN
    // A single-share build keeps an unused 8-bit mask port so the width stays legal.
    input  logic [8*((NUM_SHARES > 1) ? (NUM_SHARES - 1) : 1)-1:0] RandxDI,
`endif
    output logic                    OutValidxSO,
    input  logic                    OutReadyxSI,
    output logic [MODE_W-1:0]       ModexSO,
    output logic [8*NUM_SHARES-1:0] DataOutxDO
);

    localparam int W = 8 * NUM_SHARES;

    // Handshake: a beat moves across a boundary on a rising edge where valid and ready are both high.
    logic [PIPE_STAGES:0] valid_chain;
    logic [PIPE_STAGES:0] ready_chain;
    logic [MODE_W-1:0]    mode_chain [PIPE_STAGES+1];
    logic [W-1:0]         data_chain [PIPE_STAGES+1];
    logic [W-1:0]         mapped;

    always_comb begin
        mapped = '0;
        for (int i = 0; i < NUM_SHARES; i++) begin
            mapped[8*i +: 8] = map_byte(ModexSI, DataInxDI[8*i +: 8]);
        end
    end

`ifdef LIN_MAP_REFRESH_EN
    logic [W-1:0] refreshed;
    logic [7:0]   mask_sum;

    // Share 0 absorbs every mask, so the XOR of all shares is unchanged.
    always_comb begin
        refreshed = mapped;
        mask_sum  = '0;
        for (int i = 1; i < NUM_SHARES; i++) begin
            refreshed[8*i +: 8] = mapped[8*i +: 8] ^ RandxDI[8*(i-1) +: 8];
            mask_sum            = mask_sum ^ RandxDI[8*(i-1) +: 8];
        end
        refreshed[7:0] = mapped[7:0] ^ mask_sum;
    end

    assign data_chain[0] = refreshed;
`else
    assign data_chain[0] = mapped;
`endif

    assign valid_chain[0] = InValidxSI;
    assign mode_chain[0]  = ModexSI;

    // Slot s accepts when the output is ready or any slot from s onward is empty;
    // written flat from the registered valids so no combinational loop forms.
    always_comb begin
        ready_chain = '0;
        for (int s = 0; s <= PIPE_STAGES; s++) begin
            ready_chain[s] = OutReadyxSI;
            for (int t = s; t < PIPE_STAGES; t++) begin
                if (!valid_chain[t+1]) ready_chain[s] = 1'b1;
            end
        end
    end

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        lin_map_stage #(.W(W)) u_stage (
            .clk       (ClkxCI),
            .rst_n     (RstxBI),
            .in_valid  (valid_chain[s]),
            .in_mode   (mode_chain[s]),
            .in_data   (data_chain[s]),
            .out_valid (valid_chain[s+1]),
            .out_ready (ready_chain[s+1]),
            .out_mode  (mode_chain[s+1]),
            .out_data  (data_chain[s+1])
        );
    end

    assign InReadyxSO  = ready_chain[0];
    assign OutValidxSO = valid_chain[PIPE_STAGES];
    assign ModexSO     = mode_chain[PIPE_STAGES];
    assign DataOutxDO  = data_chain[PIPE_STAGES];

endmodule

// File: tb/tb_lin_map_pipe.sv
// Bench for lin_map_pipe: three depths (0, 1, 3) on shared stimulus, each
// with its own expected queue; LIN_MAP_REFRESH_EN selects the refresh build.
module tb_lin_map_pipe;

`ifdef LIN_MAP_REFRESH_EN
    localparam bit REFRESH = 1'b1;
`else
    localparam bit REFRESH = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  mode_in;
    logic [15:0] data_in;
    logic [7:0]  rand_in;
    logic        out_ready;

    logic        p0_in_ready, p0_out_valid;
    logic [1:0]  p0_mode;
    logic [15:0] p0_data;
    logic        p1_in_ready, p1_out_valid;
    logic [1:0]  p1_mode;
    logic [15:0] p1_data;
    logic        p3_in_ready, p3_out_valid;
    logic [1:0]  p3_mode;
    logic [15:0] p3_data;

    int assertions = 0;
    int failures   = 0;

    logic [17:0] exp_q0[$];
    logic [17:0] exp_q1[$];
    logic [17:0] exp_q3[$];

    logic        hold1, hold3;
    logic [17:0] last1, last3;
    logic [17:0] stall_exp;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    lin_map_pipe #(.NUM_SHARES(2), .PIPE_STAGES(0)) u_p0 (
        .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(in_valid), .InReadyxSO(p0_in_ready),
        .ModexSI(mode_in), .DataInxDI(data_in),
`ifdef LIN_MAP_REFRESH_EN
        .RandxDI(rand_in),
`endif
        .OutValidxSO(p0_out_valid), .OutReadyxSI(out_ready), .ModexSO(p0_mode), .DataOutxDO(p0_data)
    );

    lin_map_pipe #(.NUM_SHARES(2), .PIPE_STAGES(1)) u_p1 (
        .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(in_valid), .InReadyxSO(p1_in_ready),
        .ModexSI(mode_in), .DataInxDI(data_in),
`ifdef LIN_MAP_REFRESH_EN
        .RandxDI(rand_in),
`endif
        .OutValidxSO(p1_out_valid), .OutReadyxSI(out_ready), .ModexSO(p1_mode), .DataOutxDO(p1_data)
    );

    lin_map_pipe #(.NUM_SHARES(2), .PIPE_STAGES(3)) u_p3 (
        .ClkxCI(clk), .RstxBI(rst_n), .InValidxSI(in_valid), .InReadyxSO(p3_in_ready),
        .ModexSI(mode_in), .DataInxDI(data_in),
`ifdef LIN_MAP_REFRESH_EN
        .RandxDI(rand_in),
`endif
        .OutValidxSO(p3_out_valid), .OutReadyxSI(out_ready), .ModexSO(p3_mode), .DataOutxDO(p3_data)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_map(input logic [1:0] m, input logic [7:0] x);
        logic [7:0] in_cols  [8] = '{8'hFF, 8'hA9, 8'h81, 8'h09, 8'h48, 8'hF2, 8'hF3, 8'h98};
        logic [7:0] out_cols [8] = '{8'h24, 8'h03, 8'h04, 8'hDC, 8'h0B, 8'h9E, 8'h2D, 8'h58};
        logic [7:0] y = 8'h00;
        if (m[1]) return x;
        for (int b = 0; b < 8; b++) begin
            if (x[b]) y = y ^ (m[0] ? in_cols[b] : out_cols[b]);
        end
        return y;
    endfunction

    function automatic logic [17:0] ref_beat(input logic [1:0] m, input logic [15:0] d, input logic [7:0] r);
        logic [7:0] s0 = ref_map(m, d[7:0]);
        logic [7:0] s1 = ref_map(m, d[15:8]);
        if (REFRESH) begin
            s0 = s0 ^ r;
            s1 = s1 ^ r;
        end
        return {m, s1, s0};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_step(input int id, input logic acc, input logic [17:0] acc_word,
                           input logic emit, input logic [17:0] got);
        logic [17:0] want;
        if (acc) begin
            case (id)
                0:       exp_q0.push_back(acc_word);
                1:       exp_q1.push_back(acc_word);
                default: exp_q3.push_back(acc_word);
            endcase
        end
        if (emit) begin
            want = 'x;
            case (id)
                0:       if (exp_q0.size() > 0) want = exp_q0.pop_front();
                1:       if (exp_q1.size() > 0) want = exp_q1.pop_front();
                default: if (exp_q3.size() > 0) want = exp_q3.pop_front();
            endcase
            check($sformatf("sb_p%0d", id), {14'd0, got}, {14'd0, want});
        end
    endtask

    // Scoreboard sampling on the falling edge, between input drive and the next transfer edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold1 = 1'b0;
            hold3 = 1'b0;
        end else begin
            sb_step(0, in_valid && p0_in_ready, ref_beat(mode_in, data_in, rand_in),
                    p0_out_valid && out_ready, {p0_mode, p0_data});
            sb_step(1, in_valid && p1_in_ready, ref_beat(mode_in, data_in, rand_in),
                    p1_out_valid && out_ready, {p1_mode, p1_data});
            sb_step(3, in_valid && p3_in_ready, ref_beat(mode_in, data_in, rand_in),
                    p3_out_valid && out_ready, {p3_mode, p3_data});
            if (hold1) check("p1_hold", {13'd0, p1_out_valid, p1_mode, p1_data}, {13'd0, 1'b1, last1});
            if (hold3) check("p3_hold", {13'd0, p3_out_valid, p3_mode, p3_data}, {13'd0, 1'b1, last3});
            hold1 = p1_out_valid && !out_ready;
            hold3 = p3_out_valid && !out_ready;
            last1 = {p1_mode, p1_data};
            last3 = {p3_mode, p3_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] d);
        in_valid = v;
        mode_in  = m;
        data_in  = d;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        rand_in = 8'h00;
        drive(1'b0, 2'd0, 16'h0000);
        repeat (3) cyc();

        check("rst_p1_valid", {31'd0, p1_out_valid}, 32'd0);
        check("rst_p1_data", {16'd0, p1_data}, 32'd0);
        check("rst_p3_valid", {31'd0, p3_out_valid}, 32'd0);
        check("rst_p3_data", {14'd0, p3_mode, p3_data}, 32'd0);

        rst_n = 1'b1;
        #1;
        check("rel_p1_ready", {31'd0, p1_in_ready}, 32'd1);
        check("rel_p3_ready", {31'd0, p3_in_ready}, 32'd1);
        check("p0_ready_follows", {31'd0, p0_in_ready}, 32'd0);
        cyc();

        // Input map of 0x01/0x00.
        out_ready = 1'b1;
        drive(1'b1, 2'd1, 16'h0001);
        #1;
        check("p0_comb_valid", {31'd0, p0_out_valid}, 32'd1);
        check("p0_comb_data", {16'd0, p0_data}, 32'h00FF);
        cyc();
        in_valid = 1'b0;
        check("p1_inmap_valid", {31'd0, p1_out_valid}, 32'd1);
        check("p1_inmap_data", {14'd0, p1_mode, p1_data}, {14'd0, 2'd1, 16'h00FF});

        // Output map of 0x01/0x01 recombines to zero.
        drive(1'b1, 2'd0, 16'h0101);
        cyc();
        in_valid = 1'b0;
        check("p1_outmap_data", {16'd0, p1_data}, 32'h2424);
        check("p1_outmap_recomb", {24'd0, p1_data[15:8] ^ p1_data[7:0]}, 32'h00);

`ifdef LIN_MAP_REFRESH_EN
        rand_in = 8'h5A;
        drive(1'b1, 2'd1, 16'h0001);
        #1;
        check("p0_refresh_data", {16'd0, p0_data}, 32'h5AA5);
        cyc();
        in_valid = 1'b0;
        rand_in = 8'h00;
        check("p1_refresh_data", {16'd0, p1_data}, 32'h5AA5);
        check("p1_refresh_recomb", {24'd0, p1_data[15:8] ^ p1_data[7:0]}, 32'hFF);
`endif

        // Random traffic with random backpressure.
        for (int i = 0; i < 150; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)));
            rand_in   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();
        check("rand_q0_empty", exp_q0.size(), 32'd0);
        check("rand_q1_empty", exp_q1.size(), 32'd0);
        check("rand_q3_empty", exp_q3.size(), 32'd0);

        // Ten back-to-back beats through three stages: outputs in cycles 3..12.
        for (int c = 0; c < 15; c++) begin
            check($sformatf("p3_stream_valid_c%0d", c), {31'd0, p3_out_valid}, {31'd0, (c >= 3 && c < 13)});
            check("p3_stream_ready", {31'd0, p3_in_ready}, 32'd1);
            drive(c < 10, 2'(c), 16'($urandom_range(0, 65535)));
            cyc();
        end
        check("stream_q3_empty", exp_q3.size(), 32'd0);

        // Stall with a full pipe: three beats fill it, then five stalled cycles.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'(k + 1), 16'h1357 + 16'(k));
            if (k == 0) stall_exp = ref_beat(mode_in, data_in, rand_in);
            #1;
            check($sformatf("p3_fill_ready_%0d", k), {31'd0, p3_in_ready}, 32'd1);
            cyc();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("p3_stall_ready", {31'd0, p3_in_ready}, 32'd0);
            check("p3_stall_valid", {31'd0, p3_out_valid}, 32'd1);
            check("p3_stall_data", {14'd0, p3_mode, p3_data}, {14'd0, stall_exp});
            cyc();
        end
        out_ready = 1'b1;
        repeat (5) cyc();
        check("stall_q3_empty", exp_q3.size(), 32'd0);
        check("stall_q1_empty", exp_q1.size(), 32'd0);

        // Reset with two beats in flight.
        drive(1'b1, 2'd0, 16'hA55A);
        cyc();
        drive(1'b1, 2'd1, 16'h3CC3);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("pre_rst_p3_valid", {31'd0, p3_out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_p3_valid", {31'd0, p3_out_valid}, 32'd0);
        check("mid_rst_p3_data", {16'd0, p3_data}, 32'd0);
        check("mid_rst_p1_valid", {31'd0, p1_out_valid}, 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        exp_q3.delete();
        cyc();
        rst_n = 1'b1;
        #1;
        check("post_rst_p3_ready", {31'd0, p3_in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("post_rst_no_stale", {30'd0, p1_out_valid, p3_out_valid}, 32'd0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
